vga_frame_scanner: RTL
======================

// Module: vga_frame_scanner
// PURPOSE
//  Pixel-sink end of the plot interface (x, y, colour, writeEn) driven by the board/piece drawing logic.
//  Stores plotted pixels in a 160x120x3 frame buffer.
//  Continuously scans that buffer out as 640x480@60 VGA, with 4x4 pixel replication.
//  Sits between the game drawing FSMs and the board's VGA DAC pins.
// PARAMETERS
//  FB_W        160     frame buffer width (pixels)
//  FB_H        120     frame buffer height (pixels)
//  SCALE_SHIFT 2       log2 replication factor (160*4=640, 120*4=480)
//  H_VIS/H_FP/H_SYNC/H_BP  640/16/96/48   horizontal timing (pixel clocks); total 800
//  V_VIS/V_FP/V_SYNC/V_BP  480/10/2/33    vertical timing (lines); total 525
//  BG_COLOUR   3'b000  colour used for buffer clear (FB_CLEAR_EN only)
// PORTS
//  clk         in   1  system clock, 50 MHz
//  reset       in   1  synchronous, active-high
//  x           in   8  plot column, 0..159
//  y           in   7  plot row, 0..119
//  colour      in   3  {R,G,B} one bit each
//  writeEn     in   1  plot strobe; one pixel written per cycle it is high
//  busy        out  1  high while writes are being dropped (clear in progress); else 0
//  vga_r/g/b   out  8  colour channels; each = {8{colour bit}}
//  vga_hs      out  1  horizontal sync, active low
//  vga_vs      out  1  vertical sync, active low
//  vga_blank_n out  1  high in the visible region
//  vga_sync_n  out  1  tied 0
//  vga_clk     out  1  25 MHz pixel clock = pix_en register
// BEHAVIOUR
//  Reset values:
//   - pix_en=0, hcount=0, vcount=0.
//   - vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0, busy=0.
//  Write port:
//   - Each clk with writeEn=1 and x<FB_W and y<FB_H writes mem[y*160+x] <= colour.
//   - Address math is 15 bits wide.
//   - Out-of-range writes are silently dropped and no other entry changes.
//   - Back-to-back writes are accepted every cycle; there is no handshake.
//  Pixel enable:
//   - pix_en toggles every clk.
//   - Timing counters advance only on clk edges where pix_en=1.
//  Counters:
//   - hcount runs 0..799 and wraps to 0; vcount increments on that wrap.
//   - vcount runs 0..524 and wraps to 0.
//  Read path, pipelined over 2 pixel-enabled stages:
//   - S0: rd_addr = (vcount>>2)*160 + (hcount>>2); the address is clamped when not visible.
//   - S1: synchronous memory read.
//   - S2: rgb, hs, vs and blank_n are registered together.
//   - hs/vs/blank are delayed through the same 2 stages so alignment with data is exact.
//  Sync and blank decode (evaluated at S0):
//   - hs low when hcount in [656,751].
//   - vs low when vcount in [490,491].
//   - visible when hcount<640 && vcount<480.
//   - rgb is forced to 0 when not visible.
//  Read/write collision: if the write address equals the read address in the same cycle, the read returns the OLD value.
//  Reset mid-frame: counters and pipeline restart from 0 on the next cycle. Frame buffer contents are retained unless FB_CLEAR_EN is defined.
// CONFIGURATION
//  FB_CLEAR_EN defined:
//   - After reset, an address counter writes BG_COLOUR to all 19200 entries, one per clk.
//   - busy=1 for exactly 19200 cycles following reset deassertion.
//   - User writes are dropped while busy=1.
//   - Scanout runs concurrently.
//   - Asserting reset during the clear restarts the clear from address 0.
//  FB_CLEAR_EN undefined:
//   - No clear logic; busy is constant 0.
//   - Buffer power-up content is undefined.
// TESTING
//  T1 Reset, then run 2*800*525 clks:
//   - hs falls at hcount 656 plus 2-stage pipeline delay and stays low for 96 pixel clocks.
//   - vs is low for 2 lines per frame.
//   - Frame period is 840000 clks.
//  T2 Write (x=0,y=0,c=3'b100) and (x=159,y=119,c=3'b011):
//   - Screen pixels (0..3,0..3) show r=FF, g=00, b=00.
//   - Screen pixels (636..639,476..479) show r=00, g=FF, b=FF.
//  T3 Write (x=160,y=5,c=3'b111) and (x=5,y=120,c=3'b111):
//   - Full frame dump is unchanged; no alias at addresses 5*160 or 5.
//  T4 Write a 15x15 square of 3'b110 at (20,0) on back-to-back cycles:
//   - Exactly 225 entries change.
//   - Screen region x 80..139, y 0..59 shows yellow.
//  T5 Assert reset at vcount=200 for 1 clk:
//   - Next cycle hs=1, vs=1, blank_n=0 and counters are 0.
//   - Previously written pixels persist (FB_CLEAR_EN undefined).
//  T6 With FB_CLEAR_EN defined, write (0,0,3'b111) at reset+10:
//   - busy is high for 19200 clks.
//   - The write is dropped; pixel (0,0) reads 3'b000 after the clear completes.

Source files
------------

// File: rtl/vga_frame_scanner.sv
// Plot-port frame buffer (160x120x3) scanned out as 640x480@60 VGA with 4x4 pixel replication.
// Optional `FB_CLEAR_EN: clears the buffer to BG_COLOUR after every reset, asserting busy meanwhile.
module vga_frame_scanner #(
  parameter int unsigned FB_W        = 160,
  parameter int unsigned FB_H        = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33
`ifdef FB_CLEAR_EN
  ,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       writeEn,
  output logic       busy,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);

  localparam int unsigned FB_DEPTH = FB_W * FB_H;
  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0]  HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [14:0] FB_W_A   = 15'(FB_W);
  localparam logic [7:0]  X_LIM    = 8'(FB_W);
  localparam logic [6:0]  Y_LIM    = 7'(FB_H);

  logic [2:0] mem [FB_DEPTH];

  logic       pix_en_q, pix_en_d;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  logic        vis_s0, hs_s0, vs_s0;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data_q;

  logic       hs1_q, hs1_d, vs1_q, vs1_d, blank1_q, blank1_d;
  logic       hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [2:0] rgb_q, rgb_d;

  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;
  logic        user_wr_en;
  logic [14:0] user_wr_addr;

  always_comb begin
    pix_en_d = ~pix_en_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // S0 decode; the read address is parked at 0 outside the visible window
  always_comb begin
    vis_s0  = (hcount_q < H_VIS_C) && (vcount_q < V_VIS_C);
    hs_s0   = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
    vs_s0   = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
    rd_addr = '0;
    if (vis_s0) begin
      rd_addr = 15'(vcount_q >> SCALE_SHIFT) * FB_W_A + 15'(hcount_q >> SCALE_SHIFT);
    end
  end

  always_comb begin
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    blank1_d = blank1_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    blank_d  = blank_q;
    rgb_d    = rgb_q;
    if (pix_en_q) begin
      hs1_d    = hs_s0;
      vs1_d    = vs_s0;
      blank1_d = vis_s0;
      hs_d     = hs1_q;
      vs_d     = vs1_q;
      blank_d  = blank1_q;
      rgb_d    = blank1_q ? rd_data_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en_q <= 1'b0;
      hcount_q <= '0;
      vcount_q <= '0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      blank1_q <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      pix_en_q <= pix_en_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      blank1_q <= blank1_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      rgb_q    <= rgb_d;
    end
  end

  always_comb begin
    user_wr_en   = writeEn && (x < X_LIM) && (y < Y_LIM);
    user_wr_addr = 15'(y) * FB_W_A + 15'(x);
  end

`ifdef FB_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

  localparam logic [14:0] LAST_ADDR = 15'(FB_DEPTH - 1);

  clr_state_e  clr_state_q, clr_state_d;
  logic [14:0] clr_addr_q, clr_addr_d;

  always_comb begin
    clr_state_d = clr_state_q;
    clr_addr_d  = clr_addr_q;
    if (clr_state_q == CLR_RUN) begin
      if (clr_addr_q == LAST_ADDR) begin
        clr_state_d = CLR_IDLE;
      end else begin
        clr_addr_d = clr_addr_q + 15'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_state_q <= CLR_RUN;
      clr_addr_q  <= '0;
    end else begin
      clr_state_q <= clr_state_d;
      clr_addr_q  <= clr_addr_d;
    end
  end

  // The clear owns the single write port; busy stays low while reset is held
  always_comb begin
    busy    = (clr_state_q == CLR_RUN) && !reset;
    wr_en   = user_wr_en;
    wr_addr = user_wr_addr;
    wr_data = colour;
    if (clr_state_q == CLR_RUN) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = BG_COLOUR;
    end
  end
`else
  always_comb begin
    busy    = 1'b0;
    wr_en   = user_wr_en;
    wr_addr = user_wr_addr;
    wr_data = colour;
  end
`endif

  // Read and write in the same block with <= gives old-data on a collision
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (pix_en_q) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign vga_r       = {8{rgb_q[2]}};
  assign vga_g       = {8{rgb_q[1]}};
  assign vga_b       = {8{rgb_q[0]}};
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = pix_en_q;

endmodule
